// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
// Port identifiers plus the default RAM geometry.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_id_t;

    function automatic port_id_t other_port(input port_id_t p);
        return (p == PORT_A) ? PORT_B : PORT_A;
    endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Round-robin pick with a bounded hold window for two requesters.
// Holds owner/last/hold_cnt; grants are combinational from state and requests.
module mem_arb_rr
    import mem_arb_pkg::*;
#(
    parameter int HOLD_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);

    localparam int CW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [CW-1:0] HOLD_TOP = CW'(HOLD_MAX - 1);

    port_id_t owner, owner_nx;
    port_id_t last, last_nx;
    logic [CW-1:0] hold_cnt, hold_nx;
    port_id_t pick;
    logic any;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == HOLD_TOP) ? v : v + 1'b1;
    endfunction

    // last resets to B so that A wins the very first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner    <= PORT_A;
            last     <= PORT_B;
            hold_cnt <= '0;
        end else begin
            owner    <= owner_nx;
            last     <= last_nx;
            hold_cnt <= hold_nx;
        end
    end

    always_comb begin
        gnt_a    = 1'b0;
        gnt_b    = 1'b0;
        owner_nx = owner;
        last_nx  = last;
        hold_nx  = hold_cnt;
        pick     = PORT_A;
        any      = 1'b0;
        if (rst_n) begin
            if (req_a && req_b) begin
                any = 1'b1;
                if (owner == last && hold_cnt < HOLD_TOP)
                    pick = owner;
                else
                    pick = other_port(last);
            end else if (req_a) begin
                any  = 1'b1;
                pick = PORT_A;
            end else if (req_b) begin
                any  = 1'b1;
                pick = PORT_B;
            end
        end
        if (any) begin
            gnt_a    = (pick == PORT_A);
            gnt_b    = (pick == PORT_B);
            owner_nx = pick;
            last_nx  = pick;
            hold_nx  = (pick == last) ? sat_inc(hold_cnt) : '0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port front end for the single-port 256x8 unified memory.
// Muxes the granted request onto the RAM and tracks per-port read valids.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int HOLD_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    output logic              gnt_a,
    output logic              rvalid_a,
    input  logic              req_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              gnt_b,
    output logic              rvalid_b,
    output logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] ram_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q
);

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

    mem_arb_rr #(
        .HOLD_MAX(HOLD_MAX)
    ) u_rr (
        .clk  (clk),
        .rst_n(rst_n),
        .req_a(req_a),
        .req_b(req_b),
        .gnt_a(gnt_a),
        .gnt_b(gnt_b)
    );

    // Idle cycles replay the last address/data so the RAM bus stays quiet
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            data_q   <= '0;
            rvalid_a <= 1'b0;
            rvalid_b <= 1'b0;
        end else begin
            rvalid_a <= gnt_a & ~we_a;
            rvalid_b <= gnt_b & ~we_b;
            if (gnt_a) begin
                addr_q <= addr_a;
                data_q <= wdata_a;
            end else if (gnt_b) begin
                addr_q <= addr_b;
                data_q <= wdata_b;
            end
        end
    end

    always_comb begin
        ram_we   = 1'b0;
        ram_addr = addr_q;
        ram_data = data_q;
        if (gnt_a) begin
            ram_we   = we_a;
            ram_addr = addr_a;
            ram_data = wdata_a;
        end else if (gnt_b) begin
            ram_we   = we_b;
            ram_addr = addr_b;
            ram_data = wdata_b;
        end
    end

    assign rdata = ram_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 256x8 registered RAM.
// A negedge monitor keeps a read-data scoreboard and checks idle-bus behaviour.
module tb_mem_port_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_a, we_a, req_b, we_b;
    logic [7:0] addr_a, wdata_a, addr_b, wdata_b;
    logic       gnt_a, gnt_b, rvalid_a, rvalid_b, ram_we;
    logic [7:0] rdata, ram_data, ram_addr, ram_q;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] mem       [256];
    logic [7:0] model_mem [256];
    logic [7:0] qa [$];
    logic [7:0] qb [$];
    logic       pa, pb;
    logic [7:0] last_addr;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(8), .DATA_W(8), .HOLD_MAX(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .gnt_a(gnt_a), .rvalid_a(rvalid_a),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .gnt_b(gnt_b), .rvalid_b(rvalid_b),
        .rdata(rdata), .ram_data(ram_data), .ram_addr(ram_addr),
        .ram_we(ram_we), .ram_q(ram_q)
    );

    // Registered single-port RAM, read-before-write
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_data;
        ram_q <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            qa.delete();
            qb.delete();
            pa = 1'b0;
            pb = 1'b0;
            last_addr = 8'h00;
        end else begin
            check("rvalid_a", {31'd0, rvalid_a}, {31'd0, pa});
            if (pa && qa.size() > 0) check("rdata_a", {24'd0, rdata}, {24'd0, qa.pop_front()});
            check("rvalid_b", {31'd0, rvalid_b}, {31'd0, pb});
            if (pb && qb.size() > 0) check("rdata_b", {24'd0, rdata}, {24'd0, qb.pop_front()});
            check("gnt_onehot", {31'd0, gnt_a & gnt_b}, 32'd0);
            pa = 1'b0;
            pb = 1'b0;
            if (gnt_a) begin
                check("ram_addr_a", {24'd0, ram_addr}, {24'd0, addr_a});
                check("ram_we_a", {31'd0, ram_we}, {31'd0, we_a});
                if (we_a) model_mem[addr_a] = wdata_a;
                else begin qa.push_back(model_mem[addr_a]); pa = 1'b1; end
                last_addr = addr_a;
            end else if (gnt_b) begin
                check("ram_addr_b", {24'd0, ram_addr}, {24'd0, addr_b});
                check("ram_we_b", {31'd0, ram_we}, {31'd0, we_b});
                if (we_b) model_mem[addr_b] = wdata_b;
                else begin qb.push_back(model_mem[addr_b]); pb = 1'b1; end
                last_addr = addr_b;
            end else begin
                check("idle_we", {31'd0, ram_we}, 32'd0);
                check("idle_addr", {24'd0, ram_addr}, {24'd0, last_addr});
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the granted edge
    task automatic do_acc(input bit port, input bit we, input logic [7:0] addr,
                          input logic [7:0] data);
        bit got;
        got = 1'b0;
        if (!port) begin
            req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = data;
        end else begin
            req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = data;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((!port && gnt_a) || (port && gnt_b)) begin
                got = 1'b1;
                break;
            end
        end
        check("grant_timeout", {31'd0, got}, 32'd1);
        @(posedge clk);
        #1;
        if (!port) req_a = 1'b0;
        else req_b = 1'b0;
    endtask

    initial begin
        #200000;
        check("watchdog", 32'd1, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "FAIL watchdog expired");
    end

    initial begin
        int na, nb, nrv;
        bit exp_b;
        rst_n = 1'b0;
        req_a = 1'b1; we_a = 1'b1; addr_a = 8'h30; wdata_a = 8'hA1;
        req_b = 1'b1; we_b = 1'b1; addr_b = 8'h31; wdata_b = 8'hB1;
        #1;
        check("rst_gnt_a", {31'd0, gnt_a}, 32'd0);
        check("rst_gnt_b", {31'd0, gnt_b}, 32'd0);
        check("rst_ram_we", {31'd0, ram_we}, 32'd0);
        check("rst_ram_addr", {24'd0, ram_addr}, 32'd0);
        check("rst_ram_data", {24'd0, ram_data}, 32'd0);
        check("rst_rvalid_a", {31'd0, rvalid_a}, 32'd0);
        check("rst_rvalid_b", {31'd0, rvalid_b}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("first_gnt_a", {31'd0, gnt_a}, 32'd1);
        check("first_gnt_b", {31'd0, gnt_b}, 32'd0);

        // Continuous contention: four grants per port, then hand over
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            exp_b = ((i / 4) % 2) == 1;
            check($sformatf("cont_a_%0d", i), {31'd0, gnt_a}, {31'd0, !exp_b});
            check($sformatf("cont_b_%0d", i), {31'd0, gnt_b}, {31'd0, exp_b});
        end
        @(posedge clk);
        #1;
        req_a = 1'b0; req_b = 1'b0;
        @(posedge clk);
        #1;

        // Write on B then read on A, same address
        do_acc(1'b1, 1'b1, 8'h10, 8'h5A);
        do_acc(1'b0, 1'b0, 8'h10, 8'h00);
        check("raw_rvalid_a", {31'd0, rvalid_a}, 32'd1);
        check("raw_rdata", {24'd0, rdata}, 32'h5A);
        @(posedge clk);
        #1;
        check("raw_single_pulse", {31'd0, rvalid_a}, 32'd0);

        // A alone streams reads for 10 cycles
        req_a = 1'b1; we_a = 1'b0; addr_a = 8'h30;
        na = 0; nb = 0; nrv = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            na += int'(gnt_a);
            nb += int'(gnt_b);
            nrv += int'(rvalid_a);
            if (i == 10) begin
                @(posedge clk);
                #1;
                req_a = 1'b0;
            end
        end
        check("solo_gnt_a", na, 10);
        check("solo_gnt_b", nb, 0);
        check("solo_rvalid_a", nrv, 10);

        // Reset while a read is in flight
        @(posedge clk);
        #1;
        req_a = 1'b1; we_a = 1'b0; addr_a = 8'h10;
        @(negedge clk);
        check("mid_gnt_a", {31'd0, gnt_a}, 32'd1);
        @(posedge clk);
        #1;
        req_a = 1'b0;
        check("mid_rvalid_pre", {31'd0, rvalid_a}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rvalid_async", {31'd0, rvalid_a}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_no_stale", {31'd0, rvalid_a}, 32'd0);
        @(posedge clk);
        #1;

        // Write-only stream on B with idle gaps
        for (int i = 0; i < 6; i++) begin
            do_acc(1'b1, 1'b1, 8'h50 + 8'(i), 8'hC0 + 8'(i));
            @(posedge clk);
            #1;
        end
        do_acc(1'b0, 1'b0, 8'h53, 8'h00);
        check("wstream_readback", {24'd0, rdata}, 32'hC3);
        repeat (2) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
